// File: rtl/vga_pkg.sv
// Shared VGA definitions: 640x480@60 timing constants, framebuffer geometry,
// RGB444 pixel layout and the double-buffer swap state encoding.
package vga_pkg;

    localparam int unsigned H_VISIBLE = 640;
    localparam int unsigned H_FRONT   = 16;
    localparam int unsigned H_SYNC    = 96;
    localparam int unsigned H_BACK    = 48;
    localparam int unsigned H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;

    localparam int unsigned V_VISIBLE = 480;
    localparam int unsigned V_FRONT   = 10;
    localparam int unsigned V_SYNC    = 2;
    localparam int unsigned V_BACK    = 33;
    localparam int unsigned V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int unsigned SCALE_SHIFT = 2;
    localparam int unsigned FB_W        = H_VISIBLE >> SCALE_SHIFT;
    localparam int unsigned FB_H        = V_VISIBLE >> SCALE_SHIFT;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } pixel_t;

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to keep control bits aligned with the
// framebuffer read latency; every stage resets to RST_VAL.
module vga_delay_line #(
    parameter int unsigned             WIDTH   = 1,
    parameter int unsigned             DEPTH   = 1,
    parameter logic [WIDTH-1:0]        RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                stage[i] <= RST_VAL;
            end
        end else begin
            stage[0] <= d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/vga_pixel_pipeline.sv
// Pixel stage: maps counter position to a framebuffer read, realigns the
// returned pixel with delayed syncs, and flips the front buffer at vblank.
module vga_pixel_pipeline #(
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned V_VISIBLE   = 480,
    parameter int unsigned H_CNT_W     = 10,
    parameter int unsigned V_CNT_W     = 10,
    parameter int unsigned SCALE_SHIFT = 2,
    parameter int unsigned RD_LATENCY  = 2,
    parameter int unsigned FB_ADDR_W   =
        $clog2(2 * (H_VISIBLE >> SCALE_SHIFT) * (V_VISIBLE >> SCALE_SHIFT))
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [H_CNT_W-1:0]   h_count,
    input  logic [V_CNT_W-1:0]   v_count,
    input  logic                 h_sync,
    input  logic                 v_sync,
    output logic                 fb_rd_en,
    output logic [FB_ADDR_W-1:0] fb_rd_addr,
    input  logic [11:0]          fb_rd_data,
    output logic [3:0]           vga_r,
    output logic [3:0]           vga_g,
    output logic [3:0]           vga_b,
    output logic                 vga_hs,
    output logic                 vga_vs,
    input  logic                 swap_req,
    output logic                 swap_ack,
    output logic                 front_buf
);
    import vga_pkg::*;

    localparam int unsigned FB_COLS = H_VISIBLE >> SCALE_SHIFT;
    localparam int unsigned FB_ROWS = V_VISIBLE >> SCALE_SHIFT;
    localparam int unsigned PIPE_L  = RD_LATENCY + 2;

    localparam logic [FB_ADDR_W-1:0] BANK_SIZE  = FB_ADDR_W'(FB_COLS * FB_ROWS);
    localparam logic [FB_ADDR_W-1:0] ROW_STRIDE = FB_ADDR_W'(FB_COLS);

    logic                 active;
    logic                 swap_point;
    logic [FB_ADDR_W-1:0] fb_x;
    logic [FB_ADDR_W-1:0] fb_y;
    logic [FB_ADDR_W-1:0] pixel_addr;

    assign active     = (h_count < H_CNT_W'(H_VISIBLE)) && (v_count < V_CNT_W'(V_VISIBLE));
    assign swap_point = (v_count == V_CNT_W'(V_VISIBLE)) && (h_count == '0);

    assign fb_x       = FB_ADDR_W'(h_count >> SCALE_SHIFT);
    assign fb_y       = FB_ADDR_W'(v_count >> SCALE_SHIFT);
    assign pixel_addr = (front_buf ? BANK_SIZE : '0) + fb_y * ROW_STRIDE + fb_x;

    always_ff @(posedge clk) begin
        if (rst) begin
            fb_rd_en   <= 1'b0;
            fb_rd_addr <= '0;
        end else begin
            fb_rd_en <= active;
            if (active) begin
                fb_rd_addr <= pixel_addr;
            end
        end
    end

    swap_state_t swap_state;

    // A request coinciding with the swap point is honoured without first
    // passing through SWAP_PENDING.
    always_ff @(posedge clk) begin
        if (rst) begin
            swap_state <= SWAP_IDLE;
            front_buf  <= 1'b0;
            swap_ack   <= 1'b0;
        end else if (swap_point && (swap_state == SWAP_PENDING || swap_req)) begin
            swap_state <= SWAP_IDLE;
            front_buf  <= ~front_buf;
            swap_ack   <= 1'b1;
        end else begin
            swap_ack <= 1'b0;
            if (swap_req) begin
                swap_state <= SWAP_PENDING;
            end
        end
    end

    logic [2:0] ctl_in;
    logic [2:0] ctl_dly;

    assign ctl_in = {active, h_sync, v_sync};

    // One stage short of PIPE_L: the output register below supplies the last.
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (PIPE_L - 1),
        .RST_VAL (3'b011)
    ) u_ctl_dly (
        .clk (clk),
        .rst (rst),
        .d   (ctl_in),
        .q   (ctl_dly)
    );

    pixel_t pix_q;
    logic   hs_q;
    logic   vs_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_q <= '0;
            hs_q  <= 1'b1;
            vs_q  <= 1'b1;
        end else begin
            pix_q <= ctl_dly[2] ? pixel_t'(fb_rd_data) : '0;
            hs_q  <= ctl_dly[1];
            vs_q  <= ctl_dly[0];
        end
    end

    assign vga_r  = pix_q.r;
    assign vga_g  = pix_q.g;
    assign vga_b  = pix_q.b;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;

endmodule

// File: doc/vga_pixel_pipeline.md
# vga_pixel_pipeline

Display-side pixel stage directly downstream of the horizontal and vertical timing counters. It turns the live `h_count`/`v_count` position into a framebuffer read address and issues the read. It realigns the returned pixel with equally delayed sync signals and drives the VGA RGB and sync pins, blanked outside the visible area. It also owns double-buffer selection: the drawing side requests a swap, and the block applies it only at the start of vertical blanking so no frame tears.

## Interface
Parameters:
- `H_VISIBLE`, 640, visible pixels per line
- `V_VISIBLE`, 480, visible lines per frame
- `H_CNT_W`, 10, width of `h_count`
- `V_CNT_W`, 10, width of `v_count`
- `SCALE_SHIFT`, 2, log2 of the pixel-replication factor; framebuffer is `FB_W = H_VISIBLE>>SCALE_SHIFT` by `FB_H = V_VISIBLE>>SCALE_SHIFT` (160x120)
- `RD_LATENCY`, 2, fixed framebuffer read latency in cycles (≥1)
- `FB_ADDR_W`, `$clog2(2*FB_W*FB_H)` (16), framebuffer address width covering both banks

Ports:
- `clk` in 1: pixel clock. The block has one clock.
- `rst` in 1: reset, synchronous and active-high.
- `h_count` in H_CNT_W: current pixel column
- `v_count` in V_CNT_W: current line
- `h_sync` in 1: active-low hsync from the counter
- `v_sync` in 1: active-low vsync from the counter
- `fb_rd_en` out 1: read strobe
- `fb_rd_addr` out FB_ADDR_W: read address
- `fb_rd_data` in 12: pixel {R[3:0],G[3:0],B[3:0]}, valid RD_LATENCY cycles after the address
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel outputs
- `vga_hs`, `vga_vs` out 1 each: aligned active-low syncs
- `swap_req` in 1: level request to flip the front buffer
- `swap_ack` out 1: one-cycle pulse when the flip is applied
- `front_buf` out 1: bank currently displayed

## Operation
- `active = (h_count < H_VISIBLE) && (v_count < V_VISIBLE)`.
- Address computation:
  - `fb_x = h_count >> SCALE_SHIFT`
  - `fb_y = v_count >> SCALE_SHIFT`
  - `fb_rd_addr = front_buf*FB_W*FB_H + fb_y*FB_W + fb_x`
  - Computed at full FB_ADDR_W width; no truncation before the sum.
- `fb_rd_en = active`, registered alongside the address. During blanking the address holds its last value.
- Valid pipeline:
  - `active`, `h_sync` and `v_sync` are carried through a delay line of length L = RD_LATENCY+2.
  - At the output stage, RGB is `fb_rd_data` if the delayed `active` is 1, else 0.
- Swap logic:
  - A `swap_req` seen high while idle sets `pending`.
  - At the swap point (`v_count == V_VISIBLE && h_count == 0`), if `pending` is set or `swap_req` is high on that same cycle: toggle `front_buf`, pulse `swap_ack`, clear `pending`.
  - `swap_req` held high after the ack re-arms `pending` on the next cycle, i.e. one swap per frame while held.
- Reset values:
  - RGB = 0; `vga_hs` = `vga_vs` = 1; `fb_rd_en` = 0; `fb_rd_addr` = 0.
  - `front_buf` = 0; `swap_ack` = 0; `pending` = 0.
  - Delay line cleared to active=0, syncs=1.

## Timing
- Cycle 0: counts are presented.
- Cycle 1: `fb_rd_addr`/`fb_rd_en` are registered.
- Cycle 1+RD_LATENCY: data is returned.
- Cycle L: RGB and syncs are registered at the pins. Syncs are delayed by exactly L, so the sync-to-pixel relationship from the counters is preserved.
- The `front_buf` toggle and `swap_ack` occur the cycle after the swap point.
  - The first address using the new bank appears at the first visible pixel of the next frame.
  - A bank change is never visible mid-frame.
- Reset mid-frame:
  - Outputs go to reset values the cycle after `rst` is sampled.
  - The first valid pixel appears L cycles after `rst` deasserts with active counts.
  - Any pending swap is lost.
- Wrap of `h_count`/`v_count` needs no special handling. The address is a pure function of the counts plus `front_buf`.

## Structure
- Shared package `vga_pkg`:
  - timing constants (H/V visible, porches, sync)
  - `pixel_t` (12-bit packed RGB444)
  - `FB_W`/`FB_H` localparams
- Sub-module `vga_delay_line`, parameterised by width and depth. It is used for the {active, h_sync, v_sync} bundle and reset to a parameterised value.

## Test plan
- **Basic read path:** `rst`, then h=8, v=4, front_buf=0 → cycle 1: `fb_rd_addr` = 162, `fb_rd_en` = 1; model returns 0xABC at cycle 3 → cycle 4: r=0xA, g=0xB, b=0xC.
- **Blanking:** h=700, v=10 → `fb_rd_en` = 0; 4 cycles later RGB = 0 regardless of `fb_rd_data`; sync in the range h=656..751 appears on `vga_hs` exactly 4 cycles late.
- **Swap mid-frame:** `swap_req` pulsed at v=100 → no change until v=480,h=0; then `swap_ack` = 1 for one cycle, `front_buf` = 1. Next frame at h=8, v=4 gives `fb_rd_addr` = 19362.
- **Simultaneous request:** `swap_req` rising exactly at v=480,h=0 → swap applied that frame. `swap_req` held high for three frames → exactly three acks, one per frame.
- **Reset mid-frame:** `rst` asserted at v=200 with `pending` = 1 → `front_buf` = 0, no ack at the next v=480, syncs read 1 for 4 cycles after release.
- **Corners:** h=639, v=479 → addr = 119*160+159 = 19199 (bank 0).
